// File: rtl/alu_writeback.sv
// Writeback stage behind a 1-cycle ALU: captures results and flags, then writes the register file.
// Optional WB_BYPASS_EN adds byp_valid/byp_addr/byp_data mirroring the write in progress.
module alu_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [7:0]  issue_op,
    input  logic [3:0]  issue_rd,
    output logic        issue_ready,
    input  logic [15:0] alu_acc,
    input  logic [15:0] alu_c,
    input  logic        alu_c_flag,
    input  logic        alu_z_flag,
    input  logic        alu_o_flag,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    input  logic        rf_ready,
    output logic        cf,
    output logic        zf,
    output logic        of,
    output logic        busy,
`ifdef WB_BYPASS_EN
    output logic        byp_valid,
    output logic [3:0]  byp_addr,
    output logic [15:0] byp_data,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    // Handshakes: an issue is taken on a clock edge where issue_valid && issue_ready;
    // a register-file write completes on a clock edge where rf_we && rf_ready, and
    // rf_we/rf_waddr/rf_wdata stay constant until that edge.

    state_t      state;
    logic [7:0]  op_q;
    logic [3:0]  rd_q;
    logic [15:0] c_q;

    function automatic logic op_all_flags(input logic [7:0] op);
        return (op >= 8'h01 && op <= 8'h04) || op == 8'h09;
    endfunction

    function automatic logic op_zf_only(input logic [7:0] op);
        return (op >= 8'h05 && op <= 8'h08) || op == 8'h11;
    endfunction

    function automatic logic op_no_write(input logic [7:0] op);
        return op == 8'h09 || op == 8'h11 || op == 8'h00 || op > 8'h11;
    endfunction

    function automatic logic op_two_writes(input logic [7:0] op);
        return op == 8'h06 || op == 8'h08;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            c_q      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            cf       <= 1'b0;
            zf       <= 1'b0;
            of       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        op_q  <= issue_op;
                        rd_q  <= issue_rd;
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    c_q <= alu_c;
                    if (op_all_flags(op_q)) begin
                        cf <= alu_c_flag;
                        zf <= alu_z_flag;
                        of <= alu_o_flag;
                    end else if (op_zf_only(op_q)) begin
                        zf <= alu_z_flag;
                    end
                    if (op_no_write(op_q)) begin
                        state <= IDLE;
                    end else begin
                        state    <= WR_LO;
                        rf_we    <= 1'b1;
                        rf_waddr <= rd_q;
                        rf_wdata <= alu_acc;
                    end
                end
                WR_LO: begin
                    if (rf_ready) begin
                        if (op_two_writes(op_q)) begin
                            // High half goes to the next register; rd=15 wraps to r0.
                            state    <= WR_HI;
                            rf_waddr <= rd_q + 4'd1;
                            rf_wdata <= c_q;
                        end else begin
                            state    <= IDLE;
                            rf_we    <= 1'b0;
                            rf_waddr <= '0;
                            rf_wdata <= '0;
                        end
                    end
                end
                WR_HI: begin
                    if (rf_ready) begin
                        state    <= IDLE;
                        rf_we    <= 1'b0;
                        rf_waddr <= '0;
                        rf_wdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign issue_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

`ifdef WB_BYPASS_EN
    // rf_* are only non-zero in the write states, so they can be forwarded directly.
    assign byp_valid = rf_we;
    assign byp_addr  = rf_waddr;
    assign byp_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: vector table through a write scoreboard, plus backpressure and reset-mid-write sequences.
module tb_alu_writeback;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [7:0]  issue_op;
    logic [3:0]  issue_rd;
    logic        issue_ready;
    logic [15:0] alu_acc;
    logic [15:0] alu_c;
    logic        alu_c_flag;
    logic        alu_z_flag;
    logic        alu_o_flag;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic        cf;
    logic        zf;
    logic        of;
    logic        busy;
    logic [1:0]  dbg_state;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [3:0]  byp_addr;
    logic [15:0] byp_data;
`endif

    alu_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .alu_acc     (alu_acc),
        .alu_c       (alu_c),
        .alu_c_flag  (alu_c_flag),
        .alu_z_flag  (alu_z_flag),
        .alu_o_flag  (alu_o_flag),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_ready    (rf_ready),
        .cf          (cf),
        .zf          (zf),
        .of          (of),
        .busy        (busy),
`ifdef WB_BYPASS_EN
        .byp_valid   (byp_valid),
        .byp_addr    (byp_addr),
        .byp_data    (byp_data),
`endif
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  rd;
        logic [15:0] acc;
        logic [15:0] c;
        logic [2:0]  fl;      // ALU {c,z,o}
        int          nw;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic [2:0]  exp_fl;  // {cf,zf,of} after the op
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [7:0] op, input logic [3:0] rd, input logic [15:0] acc,
                                input logic [15:0] c, input logic [2:0] fl, input int nw,
                                input logic [3:0] a0, input logic [15:0] d0, input logic [3:0] a1,
                                input logic [15:0] d1, input logic [2:0] exp_fl);
        vec_t v;
        v.op = op; v.rd = rd; v.acc = acc; v.c = c; v.fl = fl; v.nw = nw;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.exp_fl = exp_fl;
        return v;
    endfunction

    // Scoreboard: every completed write is popped and compared against the expected queue
    always @(negedge clk) begin
        if (!rst && rf_we && rf_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", rf_waddr, rf_wdata);
            end else begin
                check("write", {12'd0, rf_waddr, rf_wdata}, {12'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 40 && !issue_ready; i++) begin
            rf_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rf_ready = 1'b1;
        check(name, {31'd0, issue_ready}, 32'd1);
    endtask

    task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [15:0] acc,
                         input logic [15:0] c, input logic [2:0] fl);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rd    = rd;
        alu_acc     = acc;
        alu_c       = c;
        {alu_c_flag, alu_z_flag, alu_o_flag} = fl;
        tick();
        issue_valid = 1'b0;
        issue_op    = 8'($urandom);
        issue_rd    = 4'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        wait_ready($sformatf("v%0d_ready_in", idx));
        if (v.nw > 0) exp_q.push_back({v.a0, v.d0});
        if (v.nw > 1) exp_q.push_back({v.a1, v.d1});
        rf_ready = 1'b1;
        issue(v.op, v.rd, v.acc, v.c, v.fl);
        check($sformatf("v%0d_capt_we", idx), {31'd0, rf_we}, 32'd0);
        check($sformatf("v%0d_capt_busy", idx), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d_capt_ready", idx), {31'd0, issue_ready}, 32'd0);
        tick();
        // ALU inputs are don't-care from here on
        alu_acc = 16'($urandom);
        alu_c   = 16'($urandom);
        {alu_c_flag, alu_z_flag, alu_o_flag} = 3'($urandom);
        check($sformatf("v%0d_flags", idx), {29'd0, cf, zf, of}, {29'd0, v.exp_fl});
        if (v.nw == 0) check($sformatf("v%0d_idle_after_capt", idx), {31'd0, issue_ready}, 32'd1);
`ifdef WB_BYPASS_EN
        if (v.nw > 0)
            check($sformatf("v%0d_byp", idx), {11'd0, byp_valid, byp_addr, byp_data}, {11'd0, 1'b1, v.a0, v.d0});
`endif
        wait_ready($sformatf("v%0d_drain_timeout", idx));
        check($sformatf("v%0d_queue_empty", idx), exp_q.size(), 32'd0);
    endtask

    initial begin
        issue_valid = 1'b0; issue_op = 8'h00; issue_rd = 4'h0;
        alu_acc = 16'h0; alu_c = 16'h0;
        alu_c_flag = 1'b0; alu_z_flag = 1'b0; alu_o_flag = 1'b0;
        rf_ready = 1'b1;
        rst = 1'b1;

        //          op     rd     acc       c        fl    nw a0     d0        a1     d1        exp {cf,zf,of}
        vecs[0]  = mk(8'h01, 4'd3,  16'h0005, 16'h0000, 3'b000, 1, 4'd3,  16'h0005, 4'd0, 16'h0000, 3'b000);
        vecs[1]  = mk(8'h06, 4'd15, 16'h5678, 16'h1234, 3'b101, 2, 4'd15, 16'h5678, 4'd0, 16'h1234, 3'b000);
        vecs[2]  = mk(8'h09, 4'd5,  16'h7777, 16'h0000, 3'b100, 0, 4'd0,  16'h0000, 4'd0, 16'h0000, 3'b100);
        vecs[3]  = mk(8'h0A, 4'd2,  16'h00F0, 16'h0000, 3'b011, 1, 4'd2,  16'h00F0, 4'd0, 16'h0000, 3'b100);
        vecs[4]  = mk(8'h11, 4'd7,  16'h0000, 16'h0000, 3'b011, 0, 4'd0,  16'h0000, 4'd0, 16'h0000, 3'b110);
        vecs[5]  = mk(8'h03, 4'd9,  16'hFFFF, 16'h0000, 3'b001, 1, 4'd9,  16'hFFFF, 4'd0, 16'h0000, 3'b001);
        vecs[6]  = mk(8'h08, 4'd4,  16'h0003, 16'h0001, 3'b110, 2, 4'd4,  16'h0003, 4'd5, 16'h0001, 3'b011);
        vecs[7]  = mk(8'h00, 4'd1,  16'hAAAA, 16'h0000, 3'b100, 0, 4'd0,  16'h0000, 4'd0, 16'h0000, 3'b011);
        vecs[8]  = mk(8'h12, 4'd1,  16'hBBBB, 16'h0000, 3'b100, 0, 4'd0,  16'h0000, 4'd0, 16'h0000, 3'b011);
        vecs[9]  = mk(8'h05, 4'd6,  16'h00AA, 16'h0000, 3'b100, 1, 4'd6,  16'h00AA, 4'd0, 16'h0000, 3'b001);
        vecs[10] = mk(8'h02, 4'd0,  16'h1000, 16'h0000, 3'b100, 1, 4'd0,  16'h1000, 4'd0, 16'h0000, 3'b100);

        tick();
        tick();
        check("reset_outputs", {11'd0, rf_we, rf_waddr, rf_wdata}, 32'd0);
        check("reset_flags", {29'd0, cf, zf, of}, 32'd0);
        check("reset_busy_ready", {30'd0, busy, issue_ready}, 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Backpressure: write held for 4 cycles, issue pulses ignored meanwhile
        wait_ready("bp_ready_in");
        exp_q.push_back({4'd2, 16'h00F0});
        issue(8'h0A, 4'd2, 16'h00F0, 16'h0000, 3'b111);
        rf_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_hold%0d", i), {11'd0, rf_we, rf_waddr, rf_wdata}, {11'd0, 1'b1, 4'd2, 16'h00F0});
            issue_valid = (i < 3);
            issue_op    = 8'h01;
            issue_rd    = 4'd9;
            rf_ready    = (i == 3);
            tick();
        end
        issue_valid = 1'b0;
        check("bp_done_idle", {30'd0, busy, rf_we}, 32'd0);
        check("bp_flags_kept", {29'd0, cf, zf, of}, {29'd0, 3'b100});
        tick();
        check("bp_no_queued_issue", {30'd0, busy, issue_ready}, 32'd1);
        check("bp_queue_empty", exp_q.size(), 32'd0);

        // Reset while the high write of a MUL6 is stalled; simultaneous issue is dropped
        exp_q.push_back({4'd15, 16'hBEEF});
        rf_ready = 1'b1;
        issue(8'h06, 4'd15, 16'hBEEF, 16'hCAFE, 3'b111);
        tick();
        check("rst_lo_write", {11'd0, rf_we, rf_waddr, rf_wdata}, {11'd0, 1'b1, 4'd15, 16'hBEEF});
        tick();
        rf_ready = 1'b0;
        check("rst_hi_write", {11'd0, rf_we, rf_waddr, rf_wdata}, {11'd0, 1'b1, 4'd0, 16'hCAFE});
        check("rst_flags_before", {29'd0, cf, zf, of}, {29'd0, 3'b110});
        rst = 1'b1;
        issue_valid = 1'b1;
        issue_op = 8'h01;
        issue_rd = 4'd3;
        tick();
        rst = 1'b0;
        issue_valid = 1'b0;
        check("rst_mid_outputs", {11'd0, rf_we, rf_waddr, rf_wdata}, 32'd0);
        check("rst_mid_flags", {29'd0, cf, zf, of}, 32'd0);
        check("rst_mid_ready", {30'd0, busy, issue_ready}, 32'd1);
        tick();
        check("rst_issue_dropped", {30'd0, busy, issue_ready}, 32'd1);
        check("rst_queue_empty", exp_q.size(), 32'd0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port issue_valid, input, 1 bit: an ALU op is presented to the ALU this cycle.
REQ-004 SHALL have port issue_op, input, 8 bits: opcode of the issued op, using the ALU op encoding.
REQ-005 SHALL have port issue_rd, input, 4 bits: destination register index.
REQ-006 SHALL have port issue_ready, output, 1 bit: stage can accept an issue this cycle.
REQ-007 SHALL have ports alu_acc and alu_c, input, 16 bits each: registered ALU results.
REQ-008 SHALL have ports alu_c_flag, alu_z_flag and alu_o_flag, input, 1 bit each: registered ALU flags.
REQ-009 SHALL have ports rf_we (1 bit), rf_waddr (4 bits) and rf_wdata (16 bits), output: register-file write request.
REQ-010 SHALL have port rf_ready, input, 1 bit: register file accepts the write this cycle.
REQ-011 SHALL have ports cf, zf and of, output, 1 bit each: architectural flags; cf also drives the ALU cf input.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL accept an issue when issue_valid && issue_ready, latching issue_op and issue_rd, then move IDLE->CAPT.
REQ-014 SHALL drive issue_ready = (state == IDLE), combinationally.
REQ-015 SHALL, in CAPT (exactly 1 cycle, matching the ALU 1-cycle latency), latch alu_acc, alu_c and the ALU flags.
REQ-016 SHALL update flags at the CAPT clock edge by op class:
 - ADD/ADC/SUB/SUC (0x01-0x04) and CMP (0x09): cf, zf and of all update.
 - MUL8/MUL6/DIV8/DIV6 (0x05-0x08) and TEST (0x11): zf only.
 - 0x0A-0x10: no flag change.
REQ-017 SHALL classify writes by op:
 - CMP, TEST and opcodes outside 0x01-0x11: no write, CAPT->IDLE.
 - MUL6/DIV6: two writes, CAPT->WR_LO->WR_HI.
 - All other ops: one write, CAPT->WR_LO.
REQ-018 SHALL in WR_LO drive rf_we=1, rf_waddr=rd, rf_wdata=latched acc, holding all three stable until rf_ready=1.
REQ-019 SHALL in WR_HI drive rf_we=1, rf_waddr=(rd+1) mod 16 (rd=15 wraps to 0), rf_wdata=latched c, holding until rf_ready=1.
REQ-020 SHALL, when rf_ready=1 on the final write, return to IDLE on that edge; issue_ready rises the following cycle.
REQ-021 SHALL keep rf_we=0 in IDLE and CAPT.
REQ-022 SHALL ignore issue_valid in any state other than IDLE; no queuing.
REQ-023 SHALL ignore alu_* inputs outside CAPT.

Reset
REQ-024 SHALL on rst=1 at a clock edge force state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, cf=zf=of=0, busy=0, and clear latched op/rd/data.
REQ-025 SHALL let rst in any state, including mid-write with rf_ready=0, abandon the pending write; rf_we=0 the next cycle.
REQ-026 SHALL give rst priority over a simultaneous issue; that issue is dropped.

Configuration
REQ-027 SHALL, when WB_BYPASS_EN is defined, add outputs byp_valid (1 bit), byp_addr (4 bits) and byp_data (16 bits) equal to rf_we, rf_waddr and rf_wdata in WR_LO/WR_HI, and 0 otherwise (reset 0).
REQ-028 SHALL, when WB_BYPASS_EN is undefined, omit those ports entirely with no other behavioural change.

Verification
REQ-029 SHALL cover ADD: issue op=0x01, rd=3; CAPT acc=0x0005, flags c0 z0 o0; rf_ready=1 -> one write r3=0x0005 two cycles after issue; cf=zf=of=0; IDLE next.
REQ-030 SHALL cover MUL6 with wrap: issue op=0x06, rd=15; acc=0x5678, c=0x1234; rf_ready=1 -> r15=0x5678 then r0=0x1234 on consecutive cycles; zf=0.
REQ-031 SHALL cover CMP: op=0x09, flags c1 z0 o0 -> rf_we never asserted; cf=1, zf=0, of=0; issue_ready high one cycle after CAPT.
REQ-032 SHALL cover backpressure: op=0x0A, rd=2, acc=0x00F0, rf_ready=0 for 3 cycles -> rf_we, rf_waddr=2 and rf_wdata=0x00F0 held stable 4 cycles; issue_valid pulses meanwhile are ignored.
REQ-033 SHALL cover reset mid-write: MUL6 in WR_HI, rf_ready=0, rst=1 -> next cycle rf_we=0, flags 0, issue_ready=1.
REQ-034 SHALL cover the macro: with WB_BYPASS_EN, scenario REQ-029 shows byp_valid=1, byp_addr=3, byp_data=0x0005 in WR_LO; with it undefined the bench compiles without byp_* ports.
